// File: rtl/eq_biquad_tdm_if.sv
`default_nettype none
// ============================================================================
// Module   : eq_biquad_tdm_if
// Brief    : sample handshake, result and coefficient port bundle for the EQ.
// Revision : 1.0
// ============================================================================
interface eq_biquad_tdm_if #(
  parameter int DW    = 24,
  parameter int OW    = 29,
  parameter int CW    = 18,
  parameter int NCH   = 2,
  parameter int NBAND = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(NBAND * 5);

  logic                 in_vld;
  logic                 in_rdy;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] in_data;
  logic                 out_vld;
  logic [CHW-1:0]       out_ch;
  logic signed [OW-1:0] out_data;
  logic                 coe_wr;
  logic [AW-1:0]        coe_addr;
  logic signed [CW-1:0] coe_data;
  logic                 coe_swap;
  logic                 clip;

  modport master (
    output in_vld, in_ch, in_data, coe_wr, coe_addr, coe_data, coe_swap,
    input  in_rdy, out_vld, out_ch, out_data, clip
  );

  modport slave (
    input  in_vld, in_ch, in_data, coe_wr, coe_addr, coe_data, coe_swap,
    output in_rdy, out_vld, out_ch, out_data, clip
  );
endinterface
`default_nettype wire

// File: rtl/eq_biquad_tdm.sv
`default_nettype none
// ============================================================================
// Module   : eq_biquad_tdm
// Brief    : TDM cascaded DF-I biquad EQ on one shared multiplier, double-
//            buffered coefficients; define EQ_SAT_EN for clamping + sticky clip.
// Revision : 1.0
// ============================================================================
module eq_biquad_tdm #(
  parameter int DW    = 24,
  parameter int OW    = 29,
  parameter int CW    = 18,
  parameter int NCH   = 2,
  parameter int NBAND = 4
) (
  input wire             clk,
  input wire             sys_rst,
  eq_biquad_tdm_if.slave bus
);
  localparam int c_chw  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_bw   = (NBAND > 1) ? $clog2(NBAND) : 1;
  localparam int c_ncoe = NBAND * 5;
  localparam int c_aw   = $clog2(c_ncoe);
  localparam int c_acw  = OW + CW + 3;
  localparam logic signed [c_acw-1:0] c_rnd = c_acw'(longint'(1) << (CW - 3));
  localparam logic signed [CW-1:0]    c_one = CW'(longint'(1) << (CW - 2));
  localparam logic [c_chw:0]          c_nch = (c_chw + 1)'(NCH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic                    r_bank;
  logic                    r_swap_pend;
  logic [2:0]              r_k;
  logic [c_bw-1:0]         r_band;
  logic [c_chw-1:0]        r_ch;
  logic signed [OW-1:0]    r_x;
  logic signed [c_acw-1:0] r_acc;
  logic [c_chw-1:0]        r_out_ch;
  logic signed [OW-1:0]    r_out_data;
  logic signed [CW-1:0]    r_coef [2][c_ncoe];
  logic signed [OW-1:0]    r_x1 [NCH][NBAND];
  logic signed [OW-1:0]    r_x2 [NCH][NBAND];
  logic signed [OW-1:0]    r_y1 [NCH][NBAND];
  logic signed [OW-1:0]    r_y2 [NCH][NBAND];

  logic                    w_rdy;
  logic                    w_accept;
  logic                    w_ch_ok;
  logic                    w_last_band;
  logic [c_aw-1:0]         w_cidx;
  logic signed [CW-1:0]    w_coef;
  logic signed [OW-1:0]    w_opnd;
  logic signed [OW+CW-1:0] w_prod;
  logic signed [c_acw-1:0] w_pext;
  logic signed [c_acw-1:0] w_term;
  logic signed [c_acw-1:0] w_sum;
  logic signed [OW-1:0]    w_res;

  // A pending bank swap owns the first idle cycle, so no sample is taken then.
  assign w_rdy       = sys_rst & (r_state == S_IDLE) & ~r_swap_pend;
  assign w_accept    = w_rdy & bus.in_vld;
  assign w_ch_ok     = ({1'b0, bus.in_ch} < c_nch);
  assign w_last_band = (r_band == c_bw'(NBAND - 1));

  assign w_cidx = c_aw'(r_band) * c_aw'(5) + c_aw'(r_k);
  assign w_coef = r_coef[r_bank][w_cidx];

  always_comb begin
    w_opnd = r_x;
    case (r_k)
      3'd1:    w_opnd = r_x1[r_ch][r_band];
      3'd2:    w_opnd = r_x2[r_ch][r_band];
      3'd3:    w_opnd = r_y1[r_ch][r_band];
      3'd4:    w_opnd = r_y2[r_ch][r_band];
      default: w_opnd = r_x;
    endcase
  end

  assign w_prod = (OW + CW)'(w_coef) * (OW + CW)'(w_opnd);
  assign w_pext = c_acw'(w_prod);
  assign w_term = (r_k >= 3'd3) ? -w_pext : w_pext;
  assign w_sum  = (r_acc + c_rnd) >>> (CW - 2);

`ifdef EQ_SAT_EN
  localparam logic signed [c_acw-1:0] c_max = c_acw'((longint'(1) << (OW - 1)) - 1);
  localparam logic signed [c_acw-1:0] c_min = ~c_max;
  logic w_clamp;
  logic r_clip;

  always_comb begin
    w_clamp = 1'b1;
    w_res   = w_sum[OW-1:0];
    if (w_sum > c_max) begin
      w_res = c_max[OW-1:0];
    end else if (w_sum < c_min) begin
      w_res = c_min[OW-1:0];
    end else begin
      w_clamp = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      r_clip <= 1'b0;
    end else if (r_state == S_WB && w_clamp) begin
      r_clip <= 1'b1;
    end
  end

  assign bus.clip = r_clip;
`else
  // Two's-complement wrap: the upper accumulator bits are simply dropped.
  logic w_unused_hi;
  assign w_unused_hi = ^w_sum[c_acw-1:OW];
  assign w_res       = w_sum[OW-1:0];
  assign bus.clip    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_ch_ok) w_state_nxt = S_MAC;
      S_MAC:   if (r_k == 3'd4) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = w_last_band ? S_OUT : S_MAC;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      r_bank      <= 1'b0;
      r_swap_pend <= 1'b0;
      r_k         <= 3'd0;
      r_band      <= '0;
      r_ch        <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < c_ncoe; i++) begin
          r_coef[b][i] <= (i % 5 == 0) ? c_one : '0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        for (int n = 0; n < NBAND; n++) begin
          r_x1[c][n] <= '0;
          r_x2[c][n] <= '0;
          r_y1[c][n] <= '0;
          r_y2[c][n] <= '0;
        end
      end
    end else begin
      // Writes always hit the bank that is shadow before any swap this cycle.
      if (bus.coe_wr && (32'(bus.coe_addr) < c_ncoe)) begin
        r_coef[~r_bank][bus.coe_addr] <= bus.coe_data;
      end

      if (r_state == S_IDLE && r_swap_pend) begin
        r_bank      <= ~r_bank;
        r_swap_pend <= bus.coe_swap;
      end else if (bus.coe_swap) begin
        r_swap_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ch   <= bus.in_ch;
            r_x    <= {{(OW - DW){bus.in_data[DW-1]}}, bus.in_data};
            r_band <= '0;
            r_k    <= 3'd0;
          end
        end
        S_MAC: begin
          r_acc <= (r_k == 3'd0) ? w_term : r_acc + w_term;
          r_k   <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;
        end
        S_WB: begin
          r_x2[r_ch][r_band] <= r_x1[r_ch][r_band];
          r_x1[r_ch][r_band] <= r_x;
          r_y2[r_ch][r_band] <= r_y1[r_ch][r_band];
          r_y1[r_ch][r_band] <= w_res;
          r_x                <= w_res;
          r_band             <= r_band + c_bw'(1);
          if (w_last_band) begin
            r_out_data <= w_res;
            r_out_ch   <= r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_rdy   = w_rdy;
  assign bus.out_vld  = sys_rst & (r_state == S_OUT);
  assign bus.out_ch   = r_out_ch;
  assign bus.out_data = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_eq_biquad_tdm.sv
`default_nettype none
// Bench for eq_biquad_tdm: directed corner sequences, a vector table and
// randomized frames scored against a plain-arithmetic cascade model.
module tb_eq_biquad_tdm;
  localparam int DW    = 24;
  localparam int OW    = 29;
  localparam int CW    = 18;
  localparam int NCH   = 2;
  localparam int NBAND = 4;
  localparam int NC    = NBAND * 5;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW    = $clog2(NC);
  localparam int LAT   = 6 * NBAND + 1;
  localparam longint MAXV = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  typedef struct {
    int     ch;
    longint x;
    longint y;
  } vec_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 clk = ~clk;

  eq_biquad_tdm_if #(.DW(DW), .OW(OW), .CW(CW), .NCH(NCH), .NBAND(NBAND)) bus ();

  eq_biquad_tdm #(.DW(DW), .OW(OW), .CW(CW), .NCH(NCH), .NBAND(NBAND)) dut (
    .clk    (clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  longint m_coef [2][NC];
  int     m_act;
  longint m_x1 [NCH][NBAND];
  longint m_x2 [NCH][NBAND];
  longint m_y1 [NCH][NBAND];
  longint m_y2 [NCH][NBAND];
  bit     m_clip;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NC; i++)
        m_coef[b][i] = (i % 5 == 0) ? (longint'(1) <<< (CW - 2)) : 0;
    for (int c = 0; c < NCH; c++)
      for (int n = 0; n < NBAND; n++) begin
        m_x1[c][n] = 0; m_x2[c][n] = 0; m_y1[c][n] = 0; m_y2[c][n] = 0;
      end
    m_act  = 0;
    m_clip = 1'b0;
  endfunction

  function automatic longint limit(longint r);
`ifdef EQ_SAT_EN
    if (r > MAXV) begin m_clip = 1'b1; return MAXV; end
    if (r < MINV) begin m_clip = 1'b1; return MINV; end
    return r;
`else
    return (r <<< (64 - OW)) >>> (64 - OW);
`endif
  endfunction

  function automatic longint model_frame(int ch, longint xin);
    longint v, acc, r;
    v = xin;
    for (int b = 0; b < NBAND; b++) begin
      acc = m_coef[m_act][b*5]   * v
          + m_coef[m_act][b*5+1] * m_x1[ch][b]
          + m_coef[m_act][b*5+2] * m_x2[ch][b]
          - m_coef[m_act][b*5+3] * m_y1[ch][b]
          - m_coef[m_act][b*5+4] * m_y2[ch][b];
      r = limit((acc + (longint'(1) <<< (CW - 3))) >>> (CW - 2));
      m_x2[ch][b] = m_x1[ch][b];
      m_x1[ch][b] = v;
      m_y2[ch][b] = m_y1[ch][b];
      m_y1[ch][b] = r;
      v = r;
    end
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    bus.in_vld = 1'b0; bus.coe_wr = 1'b0; bus.coe_swap = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic coe_write(input int addr, input longint val);
    bus.coe_wr = 1'b1; bus.coe_addr = AW'(addr); bus.coe_data = CW'(val);
    @(negedge clk);
    bus.coe_wr = 1'b0;
    m_coef[1-m_act][addr] = val;
  endtask

  task automatic swap_idle();
    bus.coe_swap = 1'b1;
    @(negedge clk);
    bus.coe_swap = 1'b0;
    check("swap_rdy_low", bus.in_rdy, 0);
    @(negedge clk);
    m_act = 1 - m_act;
    check("swap_rdy_back", bus.in_rdy, 1);
  endtask

  task automatic write_and_swap(input int addr, input longint val);
    bus.coe_wr = 1'b1; bus.coe_addr = AW'(addr); bus.coe_data = CW'(val);
    bus.coe_swap = 1'b1;
    @(negedge clk);
    bus.coe_wr = 1'b0; bus.coe_swap = 1'b0;
    m_coef[1-m_act][addr] = val;
    m_act = 1 - m_act;
    @(negedge clk);
  endtask

  // Sends one sample, optionally pulsing coe_swap mid-frame; the caller owns
  // the model's bank change for such a pulse.
  task automatic run_frame(input int ch, input longint x, input int swap_at, output longint y);
    int w, lat;
    bit rdy_bad;
    longint req;
    w = 0;
    while (!bus.in_rdy && w < 50) begin @(negedge clk); w++; end
    check("rdy_wait", bus.in_rdy, 1);
    bus.in_vld = 1'b1; bus.in_ch = CHW'(ch); bus.in_data = DW'(x);
    @(negedge clk);
    bus.in_vld = 1'b0;
    lat = 1; rdy_bad = 1'b0;
    while (!bus.out_vld && lat < 60) begin
      if (bus.in_rdy) rdy_bad = 1'b1;
      bus.coe_swap = (lat == swap_at);
      @(negedge clk);
      lat++;
    end
    bus.coe_swap = 1'b0;
    if (bus.in_rdy) rdy_bad = 1'b1;
    req = model_frame(ch, x);
    y = bus.out_data;
    check("latency", lat, LAT);
    check("busy_rdy", rdy_bad, 0);
    check("out_ch", bus.out_ch, ch);
    check("out_data", y, req);
    check("clip", bus.clip, m_clip);
    @(negedge clk);
    check("vld_pulse", bus.out_vld, 0);
    check("out_hold", bus.out_data, req);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl [7];
    longint y;
    bit     neg_seen;
    int     vcnt, r, addr;
    longint val, x;

    tbl[0] = '{0, 1024, 512};
    tbl[1] = '{1, 0,    0};
    tbl[2] = '{0, 0,    256};
    tbl[3] = '{1, 0,    0};
    tbl[4] = '{0, 0,    128};
    tbl[5] = '{1, 0,    0};
    tbl[6] = '{0, 0,    64};

    bus.in_vld = 1'b0; bus.in_ch = '0; bus.in_data = '0;
    bus.coe_wr = 1'b0; bus.coe_addr = '0; bus.coe_data = '0; bus.coe_swap = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_rdy", bus.in_rdy, 0);
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_clip", bus.clip, 0);
    sys_rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", bus.in_rdy, 1);

    // Pass-through, then shadow write invisible until swapped
    run_frame(0, 1000, -1, y);
    check("pass_1000", y, 1000);
    coe_write(0, 98304);
    run_frame(0, 1000, -1, y);
    check("pre_swap_1000", y, 1000);
    check("period_rdy", bus.in_rdy, 1);
    swap_idle();
    run_frame(0, 1000, -1, y);
    check("gain_ch0", y, 1500);
    run_frame(1, 1000, -1, y);
    check("gain_ch1", y, 1500);

    // Decaying first-order section, channels interleaved
    do_reset();
    coe_write(0, 32768);
    coe_write(3, -32768);
    swap_idle();
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].ch, tbl[i].x, -1, y);
      check("decay_tbl", y, tbl[i].y);
    end

    // Swap requested mid-frame: old bank for this frame, one idle stall after
    coe_write(0, 98304);
    run_frame(1, 2000, 3, y);
    check("midswap_old_bank", y, 1000);
    check("midswap_stall", bus.in_rdy, 0);
    m_act = 1 - m_act;
    @(negedge clk);
    check("midswap_rdy", bus.in_rdy, 1);
    run_frame(1, 2000, -1, y);
    check("midswap_new_bank", y, 3000);

    // Reset in the middle of a frame
    bus.in_vld = 1'b1; bus.in_ch = '0; bus.in_data = DW'(5000);
    @(negedge clk);
    bus.in_vld = 1'b0;
    repeat (8) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    check("midrst_rdy", bus.in_rdy, 0);
    @(negedge clk);
    sys_rst = 1'b1;
    model_reset();
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_vld) vcnt++;
    end
    check("midrst_no_vld", vcnt, 0);
    check("midrst_out_data", bus.out_data, 0);
    run_frame(0, 1000, -1, y);
    check("midrst_pass", y, 1000);

    // Integrator driven by full-scale DC
    do_reset();
    coe_write(0, 65536);
    coe_write(3, -65536);
    swap_idle();
    neg_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      run_frame(0, 8388607, -1, y);
      if (y < 0) neg_seen = 1'b1;
    end
`ifdef EQ_SAT_EN
    check("sat_value", y, MAXV);
    check("clip_sticky", bus.clip, 1);
`else
    check("wrap_negative", neg_seen, 1);
    check("clip_zero", bus.clip, 0);
`endif

    // Randomized coefficients, swaps and samples
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      addr = $urandom_range(0, NC - 1);
      if (addr % 5 < 3) val = longint'($urandom_range(0, 65536)) - 32768;
      else              val = longint'($urandom_range(0, 32768)) - 16384;
      if (r < 3)       coe_write(addr, val);
      else if (r == 3) swap_idle();
      else if (r == 4) write_and_swap(addr, val);
      x = longint'(int'($urandom) >>> 8);
      run_frame($urandom_range(0, NCH - 1), x, -1, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
